// File: rtl/sparce_psru_queued.sv
// sparce_psru_queued: SparCE skip unit with a skip FIFO and a fetch handshake.
// A SASA entry whose skip condition holds is queued with its redirect target.
// The head of the queue is offered to fetch over valid/ready. After each
// accepted redirect the unit waits HOLDOFF idle cycles before the next offer.
// Optional build macro: SPARCE_PSRU_STATS_EN enables the skip statistics counters.
module sparce_psru_queued #(
   parameter int PC_W       = 32,
   parameter int SKIP_W     = 5,
   parameter int INST_BYTES = 4,
   parameter int DEPTH      = 4,
   parameter int HOLDOFF    = 2,
   parameter int CNT_W      = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              valid_in,
   output logic              in_ready,
   input  logic [PC_W-1:0]   preceding_pc,
   input  logic [SKIP_W-1:0] insts_to_skip,
   input  logic [1:0]        condition,
   input  logic              rs1_sparsity,
   input  logic              rs2_sparsity,
   input  logic              ctrl_flow_enable,
   input  logic              flush,
   output logic              skip_valid,
   output logic [PC_W-1:0]   skip_target,
   input  logic              skip_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  skips_taken,
   output logic [CNT_W-1:0]  insts_skipped
);
   localparam int AW = $clog2(DEPTH);
   localparam int SH = $clog2(INST_BYTES);
   localparam int HW = $clog2(HOLDOFF + 1) + 1;
   localparam int HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

   typedef enum logic [1:0] {S_IDLE, S_OFFER, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [AW:0]       wr_q, rd_q, cnt;
   logic [PC_W-1:0]   tgt_mem_q [DEPTH];
   logic              cond, push, pop, empty, full;
   logic [PC_W-1:0]   new_tgt;

   // Skip condition selected by the SASA condition mode
   always_comb begin
      cond = 1'b0;
      case (condition)
         2'd0: cond = rs1_sparsity | rs2_sparsity;
         2'd1: cond = rs1_sparsity & rs2_sparsity;
         2'd2: cond = rs1_sparsity;
         2'd3: cond = rs2_sparsity;
         default: cond = 1'b0;
      endcase
   end

   // Pointers carry an extra wrap bit so full and empty are distinguishable
   assign cnt      = wr_q - rd_q;
   assign empty    = (cnt == '0);
   assign full     = (cnt == (AW+1)'(DEPTH));
   assign in_ready = !full;

   // Redirect lands just past the skipped block; wraps modulo 2^PC_W
   assign new_tgt = preceding_pc + ((PC_W'(insts_to_skip) + PC_W'(1)) << SH);

   // Flush drops a same-cycle push; a flushed offer is never popped as taken
   assign push = valid_in && in_ready && cond && ctrl_flow_enable &&
                 (insts_to_skip != '0) && !flush;
   assign pop  = (state_q == S_OFFER) && skip_ready && !flush;

   // FIFO storage write; contents need no reset, pointers gate visibility
   always_ff @(posedge CLK) begin
      if (push) tgt_mem_q[wr_q[AW-1:0]] <= new_tgt;
   end

   // FIFO pointers, FSM state and hold-off counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_q    <= '0;
         rd_q    <= '0;
         state_q <= S_IDLE;
         hold_q  <= '0;
      end else begin
         wr_q    <= flush ? '0 : wr_q + (AW+1)'(push);
         rd_q    <= flush ? '0 : rd_q + (AW+1)'(pop);
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Offer sequencing: IDLE -> OFFER -> (HOLD) -> IDLE
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE:  if (!empty) state_d = S_OFFER;
         S_OFFER: begin
            if (skip_ready) begin
               if (HOLDOFF > 0) begin
                  state_d = S_HOLD;
                  hold_d  = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (hold_q == HW'(HOLD_LAST)) state_d = S_IDLE;
            else hold_d = hold_q + HW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         hold_d  = '0;
      end
   end

   assign skip_valid  = (state_q == S_OFFER);
   assign skip_target = skip_valid ? tgt_mem_q[rd_q[AW-1:0]] : '0;
   assign busy        = !empty || (state_q != S_IDLE);

`ifdef SPARCE_PSRU_STATS_EN
   logic [SKIP_W-1:0] skip_mem_q [DEPTH];
   logic [CNT_W-1:0]  taken_q, insts_q;
   logic [CNT_W:0]    insts_sum;

   assign insts_sum = {1'b0, insts_q} + (CNT_W+1)'(skip_mem_q[rd_q[AW-1:0]]);

   // Per-entry skip length travels with its target
   always_ff @(posedge CLK) begin
      if (push) skip_mem_q[wr_q[AW-1:0]] <= insts_to_skip;
   end

   // Saturating statistics; only reset clears them, flush does not
   always_ff @(posedge CLK) begin
      if (RST) begin
         taken_q <= '0;
         insts_q <= '0;
      end else if (pop) begin
         if (taken_q != '1) taken_q <= taken_q + CNT_W'(1);
         insts_q <= insts_sum[CNT_W] ? '1 : insts_sum[CNT_W-1:0];
      end
   end

   assign skips_taken   = taken_q;
   assign insts_skipped = insts_q;
`else
   assign skips_taken   = '0;
   assign insts_skipped = '0;
`endif

endmodule

// File: tb/tb_sparce_psru_queued.sv
// Directed bench for sparce_psru_queued: the driver pushes expected redirect
// targets into a scoreboard queue, an independent monitor pops and compares
// them whenever fetch accepts an offer.
module tb_sparce_psru_queued;
   localparam int PC_W = 32, SKIP_W = 5, INST_BYTES = 4, DEPTH = 4, HOLDOFF = 2, CNT_W = 4;

   logic CLK = 0, RST = 1;
   logic valid_in = 0, in_ready;
   logic [PC_W-1:0] preceding_pc = '0;
   logic [SKIP_W-1:0] insts_to_skip = '0;
   logic [1:0] condition = '0;
   logic rs1_sparsity = 0, rs2_sparsity = 0, ctrl_flow_enable = 0, flush = 0;
   logic skip_valid, skip_ready = 0, busy;
   logic [PC_W-1:0] skip_target;
   logic [CNT_W-1:0] skips_taken, insts_skipped;

   int n_vec = 0, n_err = 0;
   logic [PC_W-1:0] sb[$];

   sparce_psru_queued #(.PC_W(PC_W), .SKIP_W(SKIP_W), .INST_BYTES(INST_BYTES),
      .DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .valid_in(valid_in), .in_ready(in_ready),
      .preceding_pc(preceding_pc), .insts_to_skip(insts_to_skip),
      .condition(condition), .rs1_sparsity(rs1_sparsity), .rs2_sparsity(rs2_sparsity),
      .ctrl_flow_enable(ctrl_flow_enable), .flush(flush), .skip_valid(skip_valid),
      .skip_target(skip_target), .skip_ready(skip_ready), .busy(busy),
      .skips_taken(skips_taken), .insts_skipped(insts_skipped));

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   // Present one SASA entry; held until accepted (bounded), then withdrawn
   task automatic send(input logic [31:0] pc, input logic [4:0] sk, input logic [1:0] c,
                       input logic r1, input logic r2, input logic cfe,
                       input bit exp_push, input logic [31:0] exp_tgt);
      int n = 0;
      preceding_pc = pc; insts_to_skip = sk; condition = c;
      rs1_sparsity = r1; rs2_sparsity = r2; ctrl_flow_enable = cfe; valid_in = 1;
      while (!in_ready && n < 100) begin step(); n++; end
      if (n == 100) begin n_vec++; n_err++; $display("FAIL send_timeout: in_ready stuck 0"); end
      if (exp_push) sb.push_back(exp_tgt);
      step();
      valid_in = 0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 200) begin step(); n++; end
      chk(nm, {63'b0, busy}, 64'd0);
   endtask

   // Monitor: compare accepted targets against the scoreboard; check hold-off
   // spacing and target stability while an offer is stalled
   int cyc = 0, last_acc = -100;
   logic stalled = 0;
   logic [PC_W-1:0] stall_tgt = '0;
   always @(negedge CLK) begin
      cyc++;
      if (!RST && !flush && skip_valid) begin
         if (stalled) chk("offer_stable", skip_target, stall_tgt);
         if (skip_ready) begin
            if (sb.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_offer: got 0x%0h expected none", skip_target);
            end else begin
               chk("target", skip_target, sb.pop_front());
            end
            if (cyc - last_acc < HOLDOFF + 1)
               chk("holdoff_gap", cyc - last_acc, HOLDOFF + 1);
            last_acc = cyc;
            stalled  = 0;
         end else begin
            stalled   = 1;
            stall_tgt = skip_target;
         end
      end else begin
         stalled = 0;
      end
   end

   initial begin
      // Reset state
      step(); step();
      RST = 0;
      chk("rst_skip_valid", skip_valid, 0);
      chk("rst_skip_target", skip_target, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_skips_taken", skips_taken, 0);
      chk("rst_insts_skipped", insts_skipped, 0);

      // 1: single AND skip, latency and hold-off
      skip_ready = 1;
      send(32'h100, 5'd3, 2'd1, 1, 1, 1, 1, 32'h110);
      chk("t1_lat_valid0", skip_valid, 0);
      chk("t1_lat_busy", busy, 1);
      step();
      chk("t1_valid", skip_valid, 1);
      chk("t1_target", skip_target, 32'h110);
      step();
      chk("t1_hold1_valid", skip_valid, 0);
      chk("t1_hold1_busy", busy, 1);
      step();
      chk("t1_hold2_busy", busy, 1);
      step();
      chk("t1_idle_busy", busy, 0);

      // 2: entries that must be dropped
      send(32'h200, 5'd4, 2'd0, 0, 0, 1, 0, 0);
      chk("t2_or_busy", busy, 0);
      send(32'h200, 5'd4, 2'd3, 0, 1, 0, 0, 0);
      chk("t2_cfe_busy", busy, 0);
      send(32'h200, 5'd0, 2'd0, 1, 1, 1, 0, 0);
      chk("t2_zero_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_valid", skip_valid, 0);
         chk("t2_busy", busy, 0);
      end

      // 3: fill FIFO with fetch stalled, reject a 5th, then drain in order
      skip_ready = 0;
      send(32'h1000, 5'd1,  2'd1, 1, 1, 1, 1, 32'h1008);
      send(32'h2000, 5'd4,  2'd2, 1, 0, 1, 1, 32'h2014);
      send(32'h3000, 5'd31, 2'd3, 0, 1, 1, 1, 32'h3080);
      send(32'h4000, 5'd2,  2'd0, 1, 0, 1, 1, 32'h400C);
      chk("t3_full", in_ready, 0);
      preceding_pc = 32'h5000; insts_to_skip = 5'd1; condition = 2'd0;
      rs1_sparsity = 1; ctrl_flow_enable = 1; valid_in = 1;
      step();
      chk("t3_full_hold", in_ready, 0);
      step();
      valid_in = 0;
      skip_ready = 1;
      wait_idle("t3_drain");
      chk("t3_sb_empty", sb.size(), 0);

      // 4: target wrap-around
      send(32'hFFFF_FFF8, 5'd2, 2'd1, 1, 1, 1, 1, 32'h0000_0004);
      wait_idle("t4_drain");
      chk("t4_sb_empty", sb.size(), 0);

      // 5: flush during an accepted offer with a same-cycle push
      skip_ready = 0;
      send(32'h6000, 5'd1, 2'd0, 1, 0, 1, 1, 32'h6008);
      send(32'h6100, 5'd1, 2'd0, 1, 0, 1, 1, 32'h6108);
      send(32'h6200, 5'd1, 2'd0, 1, 0, 1, 1, 32'h6208);
      chk("t5_offer", skip_valid, 1);
      preceding_pc = 32'h7000; insts_to_skip = 5'd1; condition = 2'd0;
      rs1_sparsity = 1; ctrl_flow_enable = 1; valid_in = 1;
      flush = 1; skip_ready = 1;
      sb.delete();
      step();
      flush = 0; valid_in = 0;
      chk("t5_valid", skip_valid, 0);
      chk("t5_busy", busy, 0);
`ifdef SPARCE_PSRU_STATS_EN
      chk("t5_taken", skips_taken, 6);
      chk("t5_insts_sat", insts_skipped, 15);
`else
      chk("t5_taken", skips_taken, 0);
      chk("t5_insts", insts_skipped, 0);
`endif
      step();
      chk("t5_valid_after", skip_valid, 0);
      chk("t5_busy_after", busy, 0);

      // 6: statistics accumulate and saturate; reset clears them
      RST = 1; step(); RST = 0;
      chk("t6_rst_taken", skips_taken, 0);
      send(32'h200, 5'd3, 2'd1, 1, 1, 1, 1, 32'h210);
      send(32'h200, 5'd5, 2'd1, 1, 1, 1, 1, 32'h218);
      send(32'h200, 5'd7, 2'd1, 1, 1, 1, 1, 32'h220);
      wait_idle("t6_drain");
`ifdef SPARCE_PSRU_STATS_EN
      chk("t6_taken", skips_taken, 3);
      chk("t6_insts", insts_skipped, 15);
`else
      chk("t6_taken", skips_taken, 0);
      chk("t6_insts", insts_skipped, 0);
`endif
      for (int i = 0; i < 13; i++) begin
         send(32'h300, 5'd1, 2'd2, 1, 0, 1, 1, 32'h308);
         wait_idle("t6_sat_drain");
      end
`ifdef SPARCE_PSRU_STATS_EN
      chk("t6_taken_sat", skips_taken, 15);
      chk("t6_insts_sat", insts_skipped, 15);
`else
      chk("t6_taken_sat", skips_taken, 0);
      chk("t6_insts_sat", insts_skipped, 0);
`endif
      chk("t6_sb_empty", sb.size(), 0);

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog: guarantees termination
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
